// File: rtl/rv_pipe_pkg.sv
// ----------------------------------------------------------------------------
// rv_pipe_pkg
//   Types and constants shared by the IF/ID pipeline stages.
//   NOP_INSTR     : canonical no-op (addi x0,x0,0) driven when no word is valid
//   fetch_entry_t : one fetched instruction together with its PC
// ----------------------------------------------------------------------------
package rv_pipe_pkg;

  localparam int unsigned PIPE_XLEN = 32;
  localparam int unsigned PIPE_ILEN = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [PIPE_XLEN-1:0] pc;
    logic [PIPE_ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_buffer.sv
// ----------------------------------------------------------------------------
// instr_fetch_buffer
//   DEPTH-entry first-word-fall-through queue between fetch and decode.
//   Decouples fetch from decode stalls and supports redirect squashing.
//
//   Ports
//     clk        : rising-edge clock
//     rst_n      : asynchronous active-low reset (control state only)
//     flush      : synchronous squash of every entry, highest priority
//     in_valid   : fetch presents in_pc / in_instr
//     in_ready   : buffer accepts a word this cycle
//     in_pc      : PC of the fetched word
//     in_instr   : fetched instruction word
//     out_valid  : head entry valid for decode
//     out_ready  : decode consumes the head this cycle
//     out_pc     : PC of head entry (0 when empty)
//     out_instr  : head instruction (NOP when empty)
//     count      : occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module instr_fetch_buffer
  import rv_pipe_pkg::*;
#(
  parameter int unsigned     XLEN  = PIPE_XLEN,
  parameter int unsigned     ILEN  = PIPE_ILEN,
  parameter int unsigned     DEPTH = 4,
  parameter logic [ILEN-1:0] NOP   = NOP_INSTR
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [ILEN-1:0]            in_instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [ILEN-1:0]            out_instr,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  fetch_entry_t    r_mem [DEPTH];
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  fetch_entry_t    w_in_entry;
  fetch_entry_t    w_head;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // in_ready looks only at registered occupancy and flush, so out_ready
  // has no combinational path back to fetch; a pop while full therefore
  // re-opens the input one cycle later.
  assign in_ready  = ~w_full & ~flush;
  assign out_valid = ~w_empty;

  assign w_push = in_valid & in_ready;
  // A pop coinciding with flush is discarded along with everything else.
  assign w_pop  = out_valid & out_ready & ~flush;

  assign w_in_entry.pc    = in_pc;
  assign w_in_entry.instr = in_instr;
  assign w_head           = r_mem[r_rd_ptr];

  // Head is masked when empty so uninitialised storage never reaches decode.
  always_comb begin
    out_pc    = '0;
    out_instr = NOP;
    if (!w_empty) begin
      out_pc    = w_head.pc;
      out_instr = w_head.instr;
    end
  end

  assign count = r_count;

  // Storage carries no reset; validity is tracked entirely by r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_in_entry;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch_buffer
//   Self-checking bench for instr_fetch_buffer (DEPTH=4). Inputs change just
//   after the falling edge; outputs are sampled 1ns later, well before the
//   next rising edge. A queue-based reference tracks expected contents.
// ----------------------------------------------------------------------------
module tb_instr_fetch_buffer;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] NOPV  = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  instr_fetch_buffer #(
    .XLEN (32),
    .ILEN (32),
    .DEPTH(DEPTH),
    .NOP  (NOPV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_pc    (in_pc),
    .in_instr (in_instr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc   (out_pc),
    .out_instr(out_instr),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } word_t;

  word_t model_q[$];

  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic        ordy;
    logic        exp_ir;
    logic        exp_ov;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [2:0]  exp_cnt;
  } vec_t;

  vec_t vecs[11];

  function automatic logic [31:0] mk_instr(input logic [31:0] pc);
    return 32'hA000_0000 | pc;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of traffic checked against the reference queue.
  task automatic cycle(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                       input logic ordy, input logic fl);
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
    int          sz;
    @(negedge clk);
    in_valid = iv; in_pc = pc; in_instr = ins; out_ready = ordy; flush = fl;
    #1;
    sz    = model_q.size();
    e_ir  = (sz != DEPTH) && !fl;
    e_ov  = (sz != 0);
    e_pc  = e_ov ? model_q[0].pc    : 32'h0;
    e_ins = e_ov ? model_q[0].instr : NOPV;
    chk("in_ready",  {31'b0, in_ready},  {31'b0, e_ir});
    chk("out_valid", {31'b0, out_valid}, {31'b0, e_ov});
    chk("out_pc",    out_pc,    e_pc);
    chk("out_instr", out_instr, e_ins);
    chk("count",     {29'b0, count}, 32'(sz));
    @(posedge clk);
    if (fl) begin
      model_q.delete();
    end else begin
      if (e_ov && ordy) void'(model_q.pop_front());
      if (iv && e_ir) model_q.push_back('{pc: pc, instr: ins});
    end
  endtask

  task automatic push_word(input logic [31:0] pc);
    cycle(1'b1, pc, mk_instr(pc), 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [31:0] pc_next;

    // Expected outputs are those seen before the rising edge of each row.
    vecs[0]  = '{1'b1, 32'h00, 1'b0, 1'b1, 1'b0, 32'h0, NOPV,          3'd0};
    vecs[1]  = '{1'b1, 32'h04, 1'b0, 1'b1, 1'b1, 32'h0, 32'hA000_0000, 3'd1};
    vecs[2]  = '{1'b1, 32'h08, 1'b0, 1'b1, 1'b1, 32'h0, 32'hA000_0000, 3'd2};
    vecs[3]  = '{1'b1, 32'h0C, 1'b0, 1'b1, 1'b1, 32'h0, 32'hA000_0000, 3'd3};
    vecs[4]  = '{1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 32'h0, 32'hA000_0000, 3'd4};
    vecs[5]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 32'h0, 32'hA000_0000, 3'd4};
    vecs[6]  = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'h4, 32'hA000_0004, 3'd3};
    vecs[7]  = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'h8, 32'hA000_0008, 3'd2};
    vecs[8]  = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'hC, 32'hA000_000C, 3'd1};
    vecs[9]  = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 32'h0, NOPV,          3'd0};
    vecs[10] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 32'h0, NOPV,          3'd0};

    // Reset with random inputs (flush low so in_ready should read 1).
    rst_n = 1'b0; flush = 1'b0;
    in_valid = 1'b0; in_pc = '0; in_instr = '0; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom); out_ready = 1'($urandom);
      in_pc = $urandom; in_instr = $urandom;
      #1;
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_count",     {29'b0, count},     32'd0);
      chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
      chk("rst_out_instr", out_instr, NOPV);
      chk("rst_out_pc",    out_pc,    32'h0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    rst_n = 1'b1;

    // Fill to full, reject a fifth word, then drain in order.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      in_valid = vecs[i].iv; in_pc = vecs[i].pc; in_instr = mk_instr(vecs[i].pc);
      out_ready = vecs[i].ordy; flush = 1'b0;
      #1;
      chk($sformatf("vec%0d_in_ready", i),  {31'b0, in_ready},  {31'b0, vecs[i].exp_ir});
      chk($sformatf("vec%0d_out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].exp_ov});
      chk($sformatf("vec%0d_out_pc", i),    out_pc,    vecs[i].exp_pc);
      chk($sformatf("vec%0d_out_instr", i), out_instr, vecs[i].exp_instr);
      chk($sformatf("vec%0d_count", i),     {29'b0, count}, {29'b0, vecs[i].exp_cnt});
      @(posedge clk);
    end

    // Steady push+pop at count=2 across pointer wrap.
    pc_next = 32'h100;
    push_word(pc_next); pc_next += 4;
    push_word(pc_next); pc_next += 4;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, pc_next, mk_instr(pc_next), 1'b1, 1'b0);
      pc_next += 4;
      chk("steady_count", {29'b0, count}, 32'd2);
    end
    drain();

    // Flush at count=3 with push and pop both requested.
    push_word(32'h200); push_word(32'h204); push_word(32'h208);
    cycle(1'b1, 32'h20C, mk_instr(32'h20C), 1'b1, 1'b1);
    @(negedge clk); flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; #1;
    chk("flush_count",     {29'b0, count},     32'd0);
    chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
    push_word(32'h300); push_word(32'h304);
    drain();

    // Asynchronous reset mid-stream at count=2.
    push_word(32'h400); push_word(32'h404);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_count",     {29'b0, count},     32'd0);
    chk("arst_out_instr", out_instr, NOPV);
    model_q.delete();
    @(negedge clk); rst_n = 1'b1;
    push_word(32'h500); push_word(32'h504);
    drain();

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rpc;
      rpc = $urandom & 32'hFFFF_FFFC;
      cycle(1'($urandom), rpc, $urandom, 1'($urandom), ($urandom_range(0, 19) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
